fifo_rd_drain: RTL
==================

// Module: fifo_rd_drain
// PURPOSE
//  Read-side drain controller for asyn_fifo, in the rd_clk domain. Pops words using empty
//  and the 1-cycle registered rd_data latency, then presents them on a valid/ready stream.
//  A 2-entry skid absorbs in-flight words under back-pressure.
//  Optionally checks that words form an incrementing sequence, the pattern the write side produces.
// PARAMETERS
//  DATA_WIDTH  16  FIFO word width; must match the asyn_fifo instance.
//  CNT_WIDTH   32  width of word_cnt and err_cnt.
// PORTS
//  rd_clk        in   1           clock (FIFO read clock)
//  rd_rst_n      in   1           asynchronous active-low reset
//  drain_en      in   1           1 = drain FIFO; 0 = stop popping and finish in-flight words
//  fifo_empty    in   1           asyn_fifo empty
//  fifo_rd_data  in   DATA_WIDTH  asyn_fifo rd_data, valid the cycle after fifo_rd_en
//  fifo_rd_en    out  1           pop request to asyn_fifo
//  out_data      out  DATA_WIDTH  stream data (skid head)
//  out_valid     out  1           stream valid
//  out_ready     in   1           stream ready; transfer when out_valid & out_ready
//  busy          out  1           state != IDLE, or skid/in-flight non-empty
//  word_cnt      out  CNT_WIDTH   words transferred downstream; wraps
//  err_cnt       out  CNT_WIDTH   sequence errors; saturates at all-ones
// BEHAVIOUR
//  Reset: all registered outputs 0. FSM = IDLE. occ = 0. inflight = 0. Expected-value seed flag cleared.
//   Reset mid-operation discards skid contents and any in-flight word.
//  inflight <= fifo_rd_en. When inflight = 1, fifo_rd_data is written into the skid tail.
//  pop = out_valid & out_ready. occ = skid occupancy, 0..2. occ_next = occ + inflight - pop.
//  fifo_rd_en = (state == RUN) & !fifo_empty & (occ + inflight - pop < 2). It is combinational.
//   Never asserted while fifo_empty = 1. No word is ever dropped or duplicated.
//   Full throughput: 1 word/cycle while ready = 1 and the FIFO is non-empty.
//  out_valid = (occ != 0). out_data = skid head. Data and valid hold stable while !out_ready.
//  Simultaneous push and pop at occ = 2 cannot occur, by the fifo_rd_en rule.
//  FSM:
//   IDLE -> RUN   when drain_en = 1.
//   RUN  -> STOP  when drain_en = 0.
//   STOP -> IDLE  when inflight = 0 and occ = 0.
//   STOP -> RUN   when drain_en returns to 1.
//   STOP issues no reads and keeps delivering buffered words.
//  word_cnt increments on each pop; it wraps modulo 2^CNT_WIDTH.
// CONFIGURATION
//  `define FIFO_RD_SEQ_CHECK_EN:
//   - Each word entering the skid is compared with exp.
//   - First word after reset only seeds exp.
//   - Mismatch: err_cnt += 1 (saturating).
//   - After every word, exp <= word + 1, modulo 2^DATA_WIDTH. This resyncs after an error,
//     so one gap costs one error.
//  Macro undefined: no comparator or exp register; err_cnt is tied to 0.
// STRUCTURE
//  Shared package asyn_fifo_pkg:
//   - DATA_WIDTH default.
//   - FSM state encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2.
//  Sub-module fifo_rd_skid:
//   - 2-entry register FIFO with push, pop, head and occ.
//   - Instantiated once.
//  Top level holds the FSM, rd_en logic, counters and checker.
// TESTING (bench models asyn_fifo read port: 1-cycle registered rd_data)
//  1. FIFO preloaded 0..9, drain_en = 1, out_ready = 1
//     -> out_data 0..9 in order; fifo_rd_en high 10 consecutive cycles; word_cnt = 10; err_cnt = 0.
//  2. Stream running, out_ready = 0 for 5 cycles
//     -> at most 2 pops past the stall; occ = 2; fifo_rd_en = 0; no loss or duplicate on resume.
//  3. FIFO words 0,1,2,5,6 (SEQ_CHECK_EN defined)
//     -> err_cnt = 1 after 5; no error at 6. Macro undefined -> err_cnt stays 0.
//  4. Words 0xFFFE, 0xFFFF, 0x0000
//     -> no sequence error; wrap accepted.
//  5. drain_en dropped mid-stream with 20 words queued
//     -> no new rd_en; in-flight word still delivered; FSM reaches IDLE; busy = 0; remaining words stay in FIFO.
//  6. rd_rst_n pulsed low with occ = 2
//     -> out_valid, fifo_rd_en, word_cnt, err_cnt = 0 immediately; next word after release is seed only.

Source files
------------

// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for the asyn_fifo read-side drain logic: default word width,
// drain FSM state encoding and the skid room test used by the pop request.
package asyn_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_RUN  = ST_RUN,
        STATE_STOP = ST_STOP
    } drain_state_e;

    // True when the skid still has a free slot after this cycle's push/pop settle.
    function automatic logic skid_has_room(input logic [1:0] occ,
                                           input logic       inflight,
                                           input logic       pop);
        logic [2:0] next_occ;
        next_occ = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (next_occ < 3'd2);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register FIFO that absorbs words already requested from asyn_fifo
// while the downstream stream is stalled. Slot 0 is always the head.
module fifo_rd_skid
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] slot0_r;
    logic [DATA_WIDTH-1:0] slot1_r;
    logic [1:0]            occ_r;

    // Slot storage and occupancy; a pop shifts slot 1 forward into the head.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            slot0_r <= {DATA_WIDTH{1'b0}};
            slot1_r <= {DATA_WIDTH{1'b0}};
            occ_r   <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    occ_r   <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        slot0_r <= push_data;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign head = slot0_r;
    assign occ  = occ_r;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller for asyn_fifo: pops words, buffers them in a skid and
// streams them out. Define FIFO_RD_SEQ_CHECK_EN to enable the incrementing-sequence checker.
module fifo_rd_drain
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    drain_state_e          state_r;
    logic                  inflight_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;
    logic [1:0]            occ_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  pop_s;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .push      (inflight_r),
        .push_data (fifo_rd_data),
        .pop       (pop_s),
        .head      (head_s),
        .occ       (occ_s)
    );

    assign out_valid = (occ_s != 2'd0);
    assign out_data  = head_s;
    assign pop_s     = out_valid & out_ready;

    // Pop request must be combinational so a word can be fetched every cycle at full rate.
    assign fifo_rd_en = (state_r == STATE_RUN) & ~fifo_empty &
                        skid_has_room(occ_s, inflight_r, pop_s);

    assign busy     = (state_r != STATE_IDLE) | (occ_s != 2'd0) | inflight_r;
    assign word_cnt = word_cnt_r;

    // Drain FSM; STOP lingers until every requested word has left the skid.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_r <= STATE_IDLE;
        end else begin
            case (state_r)
                STATE_IDLE: begin
                    if (drain_en) begin
                        state_r <= STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    if (!drain_en) begin
                        state_r <= STATE_STOP;
                    end
                end
                STATE_STOP: begin
                    if (drain_en) begin
                        state_r <= STATE_RUN;
                    end else if (!inflight_r && (occ_s == 2'd0)) begin
                        state_r <= STATE_IDLE;
                    end
                end
                default: begin
                    state_r <= STATE_IDLE;
                end
            endcase
        end
    end

    // In-flight tracking for the 1-cycle read latency and the delivered-word counter.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_r <= 1'b0;
            word_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            inflight_r <= fifo_rd_en;
            if (pop_s) begin
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end
        end
    end

`ifdef FIFO_RD_SEQ_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  seeded_r;
    logic [DATA_WIDTH-1:0] exp_r;
    logic [CNT_WIDTH-1:0]  err_cnt_r;

    // Sequence checker: expectation always follows the last word, so one gap costs one error.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            seeded_r  <= 1'b0;
            exp_r     <= {DATA_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (inflight_r) begin
            if (seeded_r && (fifo_rd_data != exp_r) && (err_cnt_r != {CNT_WIDTH{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
            exp_r    <= fifo_rd_data + DATA_ONE;
            seeded_r <= 1'b1;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule
